// File: rtl/usb_command_processor.sv
// Byte-wide FIFO command processor: reads single-byte commands, assembles chunk
// nibbles and addresses, and replies with a snapshot of the panel switches.
module usb_command_processor #(
    parameter int NUM_PANELS    = 4,
    parameter int CHUNK_NIBBLES = 8,
    parameter int RD_PULSE      = 2,
    parameter int WR_PULSE      = 2,
    localparam int PW = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [4*NUM_PANELS-1:0]    panel_switches,
    input  logic                       rxf_n,
    input  logic                       txe_n,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    output logic                       data_oe,
    output logic                       rd_n,
    output logic                       wr_n,
    output logic [4*CHUNK_NIBBLES-1:0] chunk_data,
    output logic [3:0]                 chunk_addr,
    output logic [3:0]                 row_addr,
    output logic [PW-1:0]              panel_addr,
    output logic                       chunk_write_enable,
    output logic                       error,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_LOW     = 3'd1,
        DECODE     = 3'd2,
        RD_RECOVER = 3'd3,
        WR_SETUP   = 3'd4,
        WR_LOW     = 3'd5,
        WR_HOLD    = 3'd6
    } state_t;

    state_t                     state_q;
    logic [15:0]                cnt_q;
    logic [7:0]                 cmd_q;
    logic [4*NUM_PANELS-1:0]    snap_q;
    logic [3:0]                 index_q;
    logic                       pending_q;
    logic [4:0]                 ptr_q;
    logic [4*CHUNK_NIBBLES-1:0] chunk_q;
    logic [3:0]                 chunkAddr_q;
    logic [3:0]                 rowAddr_q;
    logic [PW-1:0]              panelAddr_q;
    logic                       cwe_q;
    logic                       error_q;
    logic                       rdN_q;
    logic                       wrN_q;
    logic                       oe_q;
    logic [7:0]                 dataOut_q;

    logic [3:0] replyNibble_d;
    logic [7:0] replyByte_d;
    logic [3:0] opcode;
    logic [3:0] arg;

    assign opcode = cmd_q[7:4];
    assign arg    = cmd_q[3:0];

    always_comb begin
        replyNibble_d = '0;
        for (int k = 0; k < NUM_PANELS; k++) begin
            if (index_q == 4'(k)) replyNibble_d = snap_q[4*k +: 4];
        end
        replyByte_d = {index_q + 4'd1, replyNibble_d};
    end

    // Strobes and bus enable are updated together with the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            snap_q      <= '0;
            index_q     <= '0;
            pending_q   <= 1'b0;
            ptr_q       <= '0;
            chunk_q     <= '0;
            chunkAddr_q <= '0;
            rowAddr_q   <= '0;
            panelAddr_q <= '0;
            cwe_q       <= 1'b0;
            error_q     <= 1'b0;
            rdN_q       <= 1'b1;
            wrN_q       <= 1'b1;
            oe_q        <= 1'b0;
            dataOut_q   <= '0;
        end else begin
            cwe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q && !txe_n) begin
                        state_q   <= WR_SETUP;
                        oe_q      <= 1'b1;
                        dataOut_q <= replyByte_d;
                    end else if (!pending_q && !rxf_n) begin
                        state_q <= RD_LOW;
                        rdN_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RD_LOW: begin
                    if (cnt_q == 16'(RD_PULSE - 1)) begin
                        cmd_q   <= data_in;
                        rdN_q   <= 1'b1;
                        state_q <= DECODE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DECODE: begin
                    state_q <= RD_RECOVER;
                    cnt_q   <= '0;
                    case (opcode)
                        4'd1: begin
                            snap_q    <= panel_switches;
                            index_q   <= '0;
                            pending_q <= 1'b1;
                        end
                        4'd2: begin
                            if ({28'd0, arg} < 32'(NUM_PANELS)) panelAddr_q <= arg[PW-1:0];
                            else error_q <= 1'b1;
                        end
                        4'd3: rowAddr_q   <= arg;
                        4'd4: chunkAddr_q <= arg;
                        4'd5: begin
                            if ({27'd0, ptr_q} < 32'(CHUNK_NIBBLES)) begin
                                for (int k = 0; k < CHUNK_NIBBLES; k++) begin
                                    if (ptr_q == 5'(k)) chunk_q[4*k +: 4] <= arg;
                                end
                                ptr_q <= ptr_q + 5'd1;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                        4'd6: begin
                            if ({27'd0, ptr_q} == 32'(CHUNK_NIBBLES)) cwe_q <= 1'b1;
                            else error_q <= 1'b1;
                            ptr_q <= '0;
                        end
                        4'd7: begin
                            ptr_q   <= '0;
                            error_q <= 1'b0;
                        end
                        default: error_q <= 1'b1;
                    endcase
                end
                // Two idle read cycles let the synchronised rxf_n catch up before the next read.
                RD_RECOVER: begin
                    if (cnt_q == 16'd1) state_q <= IDLE;
                    else cnt_q <= cnt_q + 16'd1;
                end
                WR_SETUP: begin
                    state_q <= WR_LOW;
                    wrN_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                WR_LOW: begin
                    if (cnt_q == 16'(WR_PULSE - 1)) begin
                        wrN_q   <= 1'b1;
                        state_q <= WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                WR_HOLD: begin
                    index_q <= index_q + 4'd1;
                    if ((index_q + 4'd1) == 4'(NUM_PANELS)) pending_q <= 1'b0;
                    oe_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    rdN_q   <= 1'b1;
                    wrN_q   <= 1'b1;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign data_out           = dataOut_q;
    assign data_oe            = oe_q;
    assign rd_n               = rdN_q;
    assign wr_n               = wrN_q;
    assign chunk_data         = chunk_q;
    assign chunk_addr         = chunkAddr_q;
    assign row_addr           = rowAddr_q;
    assign panel_addr         = panelAddr_q;
    assign chunk_write_enable = cwe_q;
    assign error              = error_q;
    assign state              = state_q;

endmodule

// File: tb/tb_usb_command_processor.sv
// Self-checking bench for usb_command_processor: command table, chunk assembly,
// switch-snapshot reply through a scoreboard queue, and reset during a write.
module tb_usb_command_processor;

    localparam int NUM_PANELS    = 4;
    localparam int CHUNK_NIBBLES = 8;
    localparam int RD_PULSE      = 2;
    localparam int WR_PULSE      = 2;
    localparam int PW            = 2;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [4*NUM_PANELS-1:0]    panel_switches;
    logic                       rxf_n;
    logic                       txe_n;
    logic [7:0]                 data_in;
    logic [7:0]                 data_out;
    logic                       data_oe;
    logic                       rd_n;
    logic                       wr_n;
    logic [4*CHUNK_NIBBLES-1:0] chunk_data;
    logic [3:0]                 chunk_addr;
    logic [3:0]                 row_addr;
    logic [PW-1:0]              panel_addr;
    logic                       chunk_write_enable;
    logic                       error;
    logic [2:0]                 state;

    usb_command_processor #(
        .NUM_PANELS(NUM_PANELS), .CHUNK_NIBBLES(CHUNK_NIBBLES),
        .RD_PULSE(RD_PULSE), .WR_PULSE(WR_PULSE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .panel_switches(panel_switches),
        .rxf_n(rxf_n), .txe_n(txe_n), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .rd_n(rd_n), .wr_n(wr_n),
        .chunk_data(chunk_data), .chunk_addr(chunk_addr), .row_addr(row_addr),
        .panel_addr(panel_addr), .chunk_write_enable(chunk_write_enable),
        .error(error), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    logic [7:0] expQ[$];
    int writes = 0;
    int readDuringReply = 0;
    int invariantErrs = 0;
    int cwePulses = 0;
    int cweLong = 0;
    logic [4*CHUNK_NIBBLES-1:0] cweData = '0;
    logic rdPrev = 1'b1;
    logic wrPrev = 1'b1;
    logic cwePrev = 1'b0;
    int rdLen = 0;

    typedef struct {
        logic [7:0] cmd;
        logic [3:0] expChunkAddr;
        logic [3:0] expRow;
        logic [1:0] expPanel;
        logic       expErr;
    } vector_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (state !== 3'd0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) reportTimeout("return to idle");
    endtask

    // Offers one command byte on the FIFO and waits until it has been consumed.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        @(negedge clk);
        data_in = b;
        rxf_n   = 1'b0;
        n = 0;
        while (rd_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) reportTimeout("rd_n fall");
        n = 0;
        while (rd_n !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) reportTimeout("rd_n rise");
        rxf_n = 1'b1;
        waitIdle();
    endtask

    // Scoreboard and protocol monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if ((rd_n === 1'b0) && (wr_n === 1'b0)) invariantErrs++;
        if ((data_oe === 1'b1) && !(state inside {3'd4, 3'd5, 3'd6})) invariantErrs++;
        if (wrPrev && (wr_n === 1'b0)) begin
            writes++;
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected write: got 0x%0h, expected no write", data_out);
            end else begin
                checkOutput("reply byte", 64'(data_out), 64'(expQ.pop_front()));
                checkOutput("oe during write", 64'(data_oe), 64'd1);
            end
        end
        if (rdPrev && (rd_n === 1'b0) && (expQ.size() > 0)) readDuringReply++;
        if (rd_n === 1'b0) rdLen++;
        if (!rdPrev && (rd_n === 1'b1)) begin
            checkOutput("rd pulse width", 64'(rdLen), 64'(RD_PULSE));
            rdLen = 0;
        end
        if (chunk_write_enable === 1'b1) begin
            cweData = chunk_data;
            if (cwePrev) cweLong++;
            else cwePulses++;
        end
        rdPrev  = rd_n;
        wrPrev  = wr_n;
        cwePrev = chunk_write_enable;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vecs[14];
        logic [15:0] sw;
        int n;
        int wBefore;

        vecs[0]  = '{8'h43, 4'h3, 4'h0, 2'd0, 1'b0};
        vecs[1]  = '{8'h31, 4'h3, 4'h1, 2'd0, 1'b0};
        vecs[2]  = '{8'h22, 4'h3, 4'h1, 2'd2, 1'b0};
        vecs[3]  = '{8'h26, 4'h3, 4'h1, 2'd2, 1'b1};
        vecs[4]  = '{8'h70, 4'h3, 4'h1, 2'd2, 1'b0};
        vecs[5]  = '{8'hF0, 4'h3, 4'h1, 2'd2, 1'b1};
        vecs[6]  = '{8'h70, 4'h3, 4'h1, 2'd2, 1'b0};
        vecs[7]  = '{8'h00, 4'h3, 4'h1, 2'd2, 1'b1};
        vecs[8]  = '{8'h7F, 4'h3, 4'h1, 2'd2, 1'b0};
        vecs[9]  = '{8'h23, 4'h3, 4'h1, 2'd3, 1'b0};
        vecs[10] = '{8'h4F, 4'hF, 4'h1, 2'd3, 1'b0};
        vecs[11] = '{8'h3E, 4'hF, 4'hE, 2'd3, 1'b0};
        vecs[12] = '{8'h24, 4'hF, 4'hE, 2'd3, 1'b1};
        vecs[13] = '{8'h70, 4'hF, 4'hE, 2'd3, 1'b0};

        reset_n        = 1'b0;
        rxf_n          = 1'b1;
        txe_n          = 1'b1;
        data_in        = 8'h00;
        panel_switches = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset strobes {rd_n,wr_n,oe}", 64'({rd_n, wr_n, data_oe}), 64'b110);
        checkOutput("reset data_out", 64'(data_out), 64'h0);
        checkOutput("reset chunk_data", 64'(chunk_data), 64'h0);
        checkOutput("reset addrs", 64'({chunk_addr, row_addr, panel_addr}), 64'h0);
        checkOutput("reset cwe/error/state", 64'({chunk_write_enable, error, state}), 64'h0);
        reset_n = 1'b1;

        $display("[TB] command table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cmd);
            checkOutput($sformatf("chunk_addr after %0h", vecs[i].cmd), 64'(chunk_addr), 64'(vecs[i].expChunkAddr));
            checkOutput($sformatf("row_addr after %0h", vecs[i].cmd), 64'(row_addr), 64'(vecs[i].expRow));
            checkOutput($sformatf("panel_addr after %0h", vecs[i].cmd), 64'(panel_addr), 64'(vecs[i].expPanel));
            checkOutput($sformatf("error after %0h", vecs[i].cmd), 64'(error), 64'(vecs[i].expErr));
        end

        $display("[TB] chunk assembly");
        for (int k = 1; k <= 8; k++) applyStimulus(8'h50 | 8'(k));
        applyStimulus(8'h60);
        checkOutput("chunk_data assembled", 64'(chunk_data), 64'h87654321);
        checkOutput("cwe pulse count", 64'(cwePulses), 64'd1);
        checkOutput("cwe extra-long cycles", 64'(cweLong), 64'd0);
        checkOutput("chunk_data during cwe", 64'(cweData), 64'h87654321);
        checkOutput("error after good chunk", 64'(error), 64'd0);

        applyStimulus(8'h5A);
        applyStimulus(8'h60);
        checkOutput("short chunk no pulse", 64'(cwePulses), 64'd1);
        checkOutput("short chunk error", 64'(error), 64'd1);
        checkOutput("nibble 0 rewritten only", 64'(chunk_data), 64'h8765432A);
        applyStimulus(8'h70);
        checkOutput("error cleared", 64'(error), 64'd0);

        for (int k = 1; k <= 9; k++) applyStimulus(8'h50 | 8'(k));
        checkOutput("overflow error", 64'(error), 64'd1);
        checkOutput("overflow data unchanged", 64'(chunk_data), 64'h87654321);
        applyStimulus(8'h60);
        checkOutput("full chunk pulse", 64'(cwePulses), 64'd2);
        checkOutput("error stays sticky", 64'(error), 64'd1);
        applyStimulus(8'h70);

        $display("[TB] switch snapshot reply");
        sw = 16'hDCBA;
        panel_switches = sw;
        applyStimulus(8'h10);
        for (int k = 0; k < NUM_PANELS; k++) expQ.push_back({4'(k + 1), sw[4*k +: 4]});
        wBefore = writes;
        @(negedge clk);
        data_in = 8'h35;
        rxf_n   = 1'b0;
        txe_n   = 1'b0;
        n = 0;
        while (writes == wBefore && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) reportTimeout("first reply write");
        panel_switches = 16'h1234;
        n = 0;
        while (rd_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) reportTimeout("read after reply");
        checkOutput("writes in reply", 64'(writes - wBefore), 64'd4);
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        checkOutput("reads during reply", 64'(readDuringReply), 64'd0);
        n = 0;
        while (rd_n !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        rxf_n = 1'b1;
        waitIdle();
        checkOutput("deferred read row_addr", 64'(row_addr), 64'h5);

        $display("[TB] reset during write");
        txe_n = 1'b1;
        sw = 16'h5678;
        panel_switches = sw;
        applyStimulus(8'h10);
        for (int k = 0; k < NUM_PANELS; k++) expQ.push_back({4'(k + 1), sw[4*k +: 4]});
        @(negedge clk);
        txe_n = 1'b0;
        n = 0;
        while (wr_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) reportTimeout("wr_n fall before reset");
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset wr_n", 64'(wr_n), 64'd1);
        checkOutput("reset data_oe", 64'(data_oe), 64'd0);
        checkOutput("reset state", 64'(state), 64'd0);
        checkOutput("reset clears chunk/row", 64'({chunk_data, row_addr}), 64'h0);
        expQ.delete();
        @(negedge clk);
        reset_n = 1'b1;
        wBefore = writes;
        repeat (30) @(negedge clk);
        checkOutput("reply abandoned", 64'(writes - wBefore), 64'd0);
        checkOutput("protocol invariants", 64'(invariantErrs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/usb_command_processor.md
USB_COMMAND_PROCESSOR -- requirements
Module: usb_command_processor

Interface
REQ-001 Parameter NUM_PANELS, default 4, number of panels; legal range 1..15.
REQ-002 Parameter CHUNK_NIBBLES, default 8, nibbles per chunk; legal range 1..16.
REQ-003 Parameter RD_PULSE, default 2, cycles rd_n is held low per byte read; legal range >=1.
REQ-004 Parameter WR_PULSE, default 2, cycles wr_n is held low per byte written; legal range >=1.
REQ-005 Localparam PW = max(1, clog2(NUM_PANELS)) SHALL set the panel address width.
REQ-006 One clock; reset is synchronous and active-low (clk, reset_n).
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 reset_n  input  1  synchronous active-low reset.
REQ-009 panel_switches  input  4*NUM_PANELS  synchronised panel selector switches; nibble k belongs to panel k.
REQ-010 rxf_n  input  1  synchronised FIFO receive-data-available, active low.
REQ-011 txe_n  input  1  synchronised FIFO transmit-space-available, active low.
REQ-012 data_in  input  8  synchronised FIFO data bus.
REQ-013 data_out  output  8  byte driven to the FIFO bus.
REQ-014 data_oe  output  1  bus output enable.
REQ-015 rd_n, wr_n  output  1 each  FIFO read and write strobes, active low.
REQ-016 chunk_data  output  4*CHUNK_NIBBLES  assembled chunk.
REQ-017 chunk_addr, row_addr  output  4 each  command-set addresses.
REQ-018 panel_addr  output  PW  command-set panel address.
REQ-019 chunk_write_enable  output  1  one-cycle chunk write strobe.
REQ-020 error  output  1  sticky protocol error flag.
REQ-021 state  output  3  current FSM state code.

Function
REQ-022 FSM states and codes: IDLE=0, RD_LOW=1, DECODE=2, RD_RECOVER=3, WR_SETUP=4, WR_LOW=5, WR_HOLD=6; code 7 SHALL go to IDLE.
REQ-023 IDLE: if a reply is pending and txe_n=0, go to WR_SETUP; else if no reply is pending and rxf_n=0, go to RD_LOW; else stay. While a reply is pending, reads are suspended.
REQ-024 RD_LOW: rd_n=0 for exactly RD_PULSE cycles; data_in is captured on the last of them; then go to DECODE.
REQ-025 DECODE: rd_n=1; execute the captured command in this one cycle; go to RD_RECOVER.
REQ-026 RD_RECOVER: rd_n=1 for 2 cycles, then go to IDLE; this covers the synchroniser latency on rxf_n.
REQ-027 Commands use opcode = byte[7:4] and arg = byte[3:0]:
- 1: snapshot all of panel_switches, set reply index to 0, mark reply pending.
- 2: if arg < NUM_PANELS, panel_addr = arg[PW-1:0]; else set error and leave panel_addr unchanged.
- 3: row_addr = arg.
- 4: chunk_addr = arg.
- 5: if nibble pointer < CHUNK_NIBBLES, write chunk_data nibble[pointer] = arg and increment the pointer; else set error and leave data unchanged.
- 6: if pointer == CHUNK_NIBBLES, pulse chunk_write_enable; else set error with no pulse. In both cases the pointer becomes 0.
- 7: clear the pointer and error.
- 0 and 8..15: set error; no other effect.
REQ-028 chunk_write_enable SHALL be registered: high for exactly the one cycle after DECODE. chunk_data, chunk_addr, row_addr and panel_addr SHALL be stable during that cycle.
REQ-029 chunk_data SHALL hold its value after a write; nibbles not rewritten keep their old values.
REQ-030 WR_SETUP: data_oe=1 and data_out = {index+1, snapshot nibble[index]} for one cycle; then go to WR_LOW.
REQ-031 WR_LOW: wr_n=0 for WR_PULSE cycles with data held; then go to WR_HOLD.
REQ-032 WR_HOLD: wr_n=1 and data_oe=1 for one cycle; increment the index; clear pending when the index reaches NUM_PANELS; go to IDLE.
REQ-033 data_oe SHALL be 0 in all states except WR_SETUP, WR_LOW and WR_HOLD; rd_n and wr_n are never low together.
REQ-034 The snapshot is immune to switch changes during the reply.
REQ-035 The error flag SHALL remain set until command 7 or reset.

Reset
REQ-036 When reset_n=0 at a clock edge, in any state including mid-strobe, the block SHALL enter IDLE.
REQ-037 Reset values: rd_n=1, wr_n=1, data_oe=0, data_out=0, chunk_data=0, chunk_addr=0, row_addr=0, panel_addr=0, chunk_write_enable=0, error=0, pointer=0, reply pending cleared, state=0.

Verification
REQ-038 Bytes 0x43,0x31,0x22 -> chunk_addr=3, row_addr=1, panel_addr=2, error=0; rd_n low RD_PULSE cycles per byte.
REQ-039 Bytes 0x51..0x58 then 0x60 with CHUNK_NIBBLES=8 -> chunk_data=0x87654321; chunk_write_enable high exactly 1 cycle; pointer=0.
REQ-040 Bytes 0x5A then 0x60 -> no chunk_write_enable pulse, error=1; then 0x70 -> error=0.
REQ-041 panel_switches=0xDCBA, byte 0x10, txe_n=0 -> wr_n pulses write 0x1A,0x2B,0x3C,0x4D in order; the switches are changed mid-reply and the bytes are unchanged; rxf_n held 0 is not serviced until the reply ends.
REQ-042 Byte 0x26 with NUM_PANELS=4 -> error=1, panel_addr unchanged; byte 0xF0 -> error=1.
REQ-043 reset_n=0 during WR_LOW -> next cycle wr_n=1, data_oe=0, state=0, reply abandoned.
